wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//   Shares the register file's single write port among N writeback producers (ALU pipe, load unit, mul/div unit).
//   Grants one producer per cycle over a valid/ready handshake; winner's rd/data drive registered wb outputs.
//   Sits between execute/memory units and the register file write port (wb_en, rd_index, wb_data).
// PARAMETERS
//   N_REQ      3   number of requesters (2..8); requester 0 = ALU, 1 = load, 2 = mul/div
//   XLEN       64  writeback data width
//   IDX_W      5   register index width
// PORTS
//   clk          in   1            clock; all state updates on rising edge
//   rst          in   1            asynchronous reset, active-high
//   stall        in   1            pipeline freeze; no grants while high
//   req_valid    in   N_REQ        per-requester writeback request
//   req_rd       in   N_REQ*IDX_W  per-requester destination index, slot i at [i*IDX_W +: IDX_W]
//   req_data     in   N_REQ*XLEN   per-requester result, slot i at [i*XLEN +: XLEN]
//   req_ready    out  N_REQ        one-hot grant, combinational; transfer = valid && ready
//   wb_en        out  1            registered write enable to register file
//   wb_rd_index  out  IDX_W        registered destination index
//   wb_data      out  XLEN         registered write data
//   grant_id     out  3            registered index of last granted requester (debug/perf)
// BEHAVIOUR
//   - Reset (async, immediate): wb_en=0, wb_rd_index=0, wb_data=0, grant_id=0, rr pointer=0; req_ready=0 while rst high.
//   - Each cycle with stall=0: the first valid requester at or after rr pointer (mod N_REQ) is granted; req_ready is one-hot or zero.
//   - Requester holds valid/rd/data stable until ready; dropping valid without ready is legal (request withdrawn).
//   - Latency: transfer in cycle T -> wb_en=1 with that rd/data in cycle T+1 (one register stage), for exactly one cycle.
//   - Throughput: one write per cycle; register file never backpressures.
//   - RR pointer: after a grant to i, pointer <= (i+1) mod N_REQ; unchanged if no grant. Max wait = N_REQ-1 grants.
//   - rd==0: request is granted and consumed normally, pointer advances, but wb_en stays 0 next cycle (x0 never written).
//   - No valid requester or stall=1: req_ready=0, wb_en<=0; wb_rd_index/wb_data/grant_id hold last value.
//   - stall asserted same cycle as valid: no grant, request waits; pointer holds.
//   - Reset mid-transfer: pending grant discarded; the requester re-presents after reset.
//   - Same rd from two requesters: serialised in grant order; later grant wins in the register file.
// CONFIGURATION
//   WB_ARB_FIXED_PRIO_EN  defined: fixed priority, lowest index wins; rr pointer removed, grant_id still updates.
//                         undefined (default): round-robin as above.
// STRUCTURE
//   Package wb_arb_pkg: N_REQ/XLEN/IDX_W defaults, requester id constants (REQ_ALU=0, REQ_LSU=1, REQ_MDU=2).
//   Sub-module rr_select: combinational rotate-and-priority-encode (req vector + pointer -> one-hot grant + index).
//   Top holds pointer register, output registers, x0 suppression and stall gating.
// TESTING
//   1. Reset: rst=1 mid-run with req_valid=3'b111 -> wb_en=0, req_ready=0, grant_id=0 immediately; after release first grant -> req 0.
//   2. Single req: req1 rd=7 data=0xDEAD_BEEF -> ready[1] same cycle; next cycle wb_en=1, wb_rd_index=7, wb_data=0xDEADBEEF.
//   3. Contention: valid=3'b111 held 6 cycles -> grants 0,1,2,0,1,2; each wb write one cycle later.
//   4. x0: req0 rd=0 data=0x55 -> ready[0]=1, next cycle wb_en=0, pointer advances to 1.
//   5. Stall: stall=1 three cycles with valid=3'b010 -> ready=0, wb_en=0; stall drops -> grant 1, wb_en=1 next cycle.
//   6. WB_ARB_FIXED_PRIO_EN defined, valid=3'b111 for 3 cycles -> grant 0 each cycle; req 1/2 never ready.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared defaults and helpers for the writeback port arbiter.
//   N_REQ_DEF / XLEN_DEF / IDX_W_DEF : default parameter values
//   ID_W                             : width of requester index / rr pointer (covers up to 8 requesters)
//   REQ_ALU / REQ_LSU / REQ_MDU      : requester slot assignments
//   next_ptr()                       : round-robin successor of a granted index
package wb_arb_pkg;

   localparam int N_REQ_DEF = 3;
   localparam int XLEN_DEF  = 64;
   localparam int IDX_W_DEF = 5;
   localparam int ID_W      = 3;

   localparam logic [ID_W-1:0] REQ_ALU = 3'd0;
   localparam logic [ID_W-1:0] REQ_LSU = 3'd1;
   localparam logic [ID_W-1:0] REQ_MDU = 3'd2;

   // Successor of idx modulo n: the requester after the winner gets first look next time.
   function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] idx, input int n);
      if (int'(idx) >= n - 1)
         return '0;
      else
         return idx + 1'b1;
   endfunction

endpackage

// File: rtl/wb_port_arbiter_rr_select.sv
// rr_select: combinational rotate-and-priority-encode.
//   req       in   N_REQ   request vector
//   ptr       in   ID_W    starting index for the search (must be < N_REQ)
//   grant     out  N_REQ   one-hot grant, zero when no request
//   grant_idx out  ID_W    index of the granted requester (0 when none)
//   any       out  1       at least one request present
module rr_select
   import wb_arb_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  grant_idx,
   output logic             any
);

   // cand[k] = (ptr + k) mod N_REQ: the k-th requester examined in this cycle's search order.
   logic [ID_W-1:0] cand [N_REQ];

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
         logic [ID_W:0] sum;
         assign sum       = {1'b0, ptr} + (ID_W+1)'(gi);
         assign cand[gi]  = (sum >= (ID_W+1)'(N_REQ)) ? ID_W'(sum - (ID_W+1)'(N_REQ))
                                                      : sum[ID_W-1:0];
      end
   endgenerate

   // The candidate index is matched against each slot number rather than used as a
   // bit select, which keeps the index width independent of N_REQ.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         for (int j = 0; j < N_REQ; j++) begin
            if (!any && (cand[k] == ID_W'(j)) && req[j]) begin
               any       = 1'b1;
               grant_idx = ID_W'(j);
               grant[j]  = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port among N_REQ writeback producers.
//   clk, rst (async active-high), stall (no grants while high)
//   req_valid/req_rd/req_data : per-requester packed request slots
//   req_ready                 : combinational one-hot grant (transfer = valid && ready)
//   wb_en/wb_rd_index/wb_data : registered write port, one cycle after the transfer
//   grant_id                  : registered index of the last granted requester
// Build option: define WB_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins);
// default is round-robin.
module wb_port_arbiter
   import wb_arb_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int XLEN  = XLEN_DEF,
   parameter int IDX_W = IDX_W_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   stall,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*IDX_W-1:0] req_rd,
   input  logic [N_REQ*XLEN-1:0]  req_data,
   output logic [N_REQ-1:0]       req_ready,
   output logic                   wb_en,
   output logic [IDX_W-1:0]       wb_rd_index,
   output logic [XLEN-1:0]        wb_data,
   output logic [ID_W-1:0]        grant_id
);

   logic [N_REQ-1:0] sel_grant;
   logic [ID_W-1:0]  sel_idx;
   logic             sel_any;
   logic [ID_W-1:0]  ptr;
   logic             fire;
   logic [IDX_W-1:0] win_rd;
   logic [XLEN-1:0]  win_data;

   // Grants are suppressed while reset is held so nothing is handed out that
   // the (reset) output registers could not capture.
   assign fire      = sel_any && !stall && !rst;
   assign req_ready = fire ? sel_grant : '0;

`ifdef WB_ARB_FIXED_PRIO_EN
   // Searching from index 0 every cycle makes the encoder a plain priority encoder.
   assign ptr = '0;
`else
   logic [ID_W-1:0] ptr_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ptr_reg <= '0;
      else if (fire)
         ptr_reg <= next_ptr(sel_idx, N_REQ);
   end

   assign ptr = ptr_reg;
`endif

   rr_select #(
      .N_REQ (N_REQ)
   ) u_rr_select (
      .req       (req_valid),
      .ptr       (ptr),
      .grant     (sel_grant),
      .grant_idx (sel_idx),
      .any       (sel_any)
   );

   // One-hot select of the winner's destination and data.
   always_comb begin
      win_rd   = '0;
      win_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (sel_grant[i]) begin
            win_rd   = req_rd[i*IDX_W +: IDX_W];
            win_data = req_data[i*XLEN +: XLEN];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_en       <= 1'b0;
         wb_rd_index <= '0;
         wb_data     <= '0;
         grant_id    <= '0;
      end else begin
         // A grant to rd==0 is consumed but never reaches the register file (x0 is hardwired).
         wb_en <= fire && (win_rd != '0);
         if (fire) begin
            wb_rd_index <= win_rd;
            wb_data     <= win_data;
            grant_id    <= sel_idx;
         end
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed self-checking bench for wb_port_arbiter (N_REQ=3, XLEN=64, IDX_W=5).
// Honours WB_ARB_FIXED_PRIO_EN: arbitration-order expectations switch with the macro.
module tb_wb_port_arbiter;

   localparam int N     = 3;
   localparam int XLEN  = 64;
   localparam int IDX_W = 5;

   logic                 clk;
   logic                 rst;
   logic                 stall;
   logic [N-1:0]         req_valid;
   logic [N*IDX_W-1:0]   req_rd;
   logic [N*XLEN-1:0]    req_data;
   logic [N-1:0]         req_ready;
   logic                 wb_en;
   logic [IDX_W-1:0]     wb_rd_index;
   logic [XLEN-1:0]      wb_data;
   logic [2:0]           grant_id;

   int checks;
   int errors;

   wb_port_arbiter #(.N_REQ(N), .XLEN(XLEN), .IDX_W(IDX_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .req_valid   (req_valid),
      .req_rd      (req_rd),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .wb_en       (wb_en),
      .wb_rd_index (wb_rd_index),
      .wb_data     (wb_data),
      .grant_id    (grant_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [IDX_W-1:0] rd, input logic [XLEN-1:0] d);
      req_rd[i*IDX_W +: IDX_W] = rd;
      req_data[i*XLEN +: XLEN] = d;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      req_valid = 3'b111;
      set_req(0, 5'd1, 64'h11);
      set_req(1, 5'd2, 64'h22);
      set_req(2, 5'd3, 64'h33);
      tick();
      tick();
      // mid-run: async reset clears outputs immediately
      rst = 1'b1;
      #1;
      checks++;
      if (wb_en !== 1'b0) begin
         errors++; $display("FAIL reset_wb_en: got %0b want 0", wb_en);
      end
      checks++;
      if (req_ready !== 3'b000) begin
         errors++; $display("FAIL reset_ready: got %b want 000", req_ready);
      end
      checks++;
      if (grant_id !== 3'd0) begin
         errors++; $display("FAIL reset_grant_id: got %0d want 0", grant_id);
      end
      checks++;
      if (wb_data !== 64'd0 || wb_rd_index !== 5'd0) begin
         errors++; $display("FAIL reset_wb_regs: got rd=%0d data=%h want 0/0", wb_rd_index, wb_data);
      end
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if (req_ready !== 3'b001) begin
         errors++; $display("FAIL reset_first_grant: got %b want 001", req_ready);
      end
      $display("test_reset: ready after release=%b", req_ready);
      req_valid = 3'b000;
      tick();
   endtask

   task automatic test_single();
      req_valid = 3'b010;
      set_req(1, 5'd7, 64'hDEAD_BEEF);
      #1;
      checks++;
      if (req_ready !== 3'b010) begin
         errors++; $display("FAIL single_ready: got %b want 010", req_ready);
      end
      tick();
      req_valid = 3'b000;
      checks++;
      if (wb_en !== 1'b1 || wb_rd_index !== 5'd7 || wb_data !== 64'hDEAD_BEEF || grant_id !== 3'd1) begin
         errors++;
         $display("FAIL single_wb: got en=%0b rd=%0d data=%h id=%0d want 1/7/deadbeef/1",
                  wb_en, wb_rd_index, wb_data, grant_id);
      end
      $display("test_single: en=%0b rd=%0d data=%h", wb_en, wb_rd_index, wb_data);
      tick();
      // exactly one cycle of wb_en; index/data hold
      checks++;
      if (wb_en !== 1'b0 || wb_rd_index !== 5'd7 || wb_data !== 64'hDEAD_BEEF) begin
         errors++;
         $display("FAIL single_one_cycle: got en=%0b rd=%0d data=%h want 0/7/deadbeef",
                  wb_en, wb_rd_index, wb_data);
      end
   endtask

   task automatic test_contention();
      logic [N-1:0] exp_ready;
      int           w;
      pulse_reset();
      set_req(0, 5'd10, 64'hA0);
      set_req(1, 5'd11, 64'hA1);
      set_req(2, 5'd12, 64'hA2);
      req_valid = 3'b111;
      for (int k = 0; k < 6; k++) begin
`ifdef WB_ARB_FIXED_PRIO_EN
         w = 0;
`else
         w = k % 3;
`endif
         exp_ready = 3'b001 << w;
         #1;
         checks++;
         if (req_ready !== exp_ready) begin
            errors++; $display("FAIL contention_ready[%0d]: got %b want %b", k, req_ready, exp_ready);
         end
         tick();
         checks++;
         if (wb_en !== 1'b1 || grant_id !== 3'(w) || wb_rd_index !== 5'(10 + w) ||
             wb_data !== 64'(160 + w)) begin
            errors++;
            $display("FAIL contention_wb[%0d]: got en=%0b id=%0d rd=%0d data=%h want 1/%0d/%0d/%h",
                     k, wb_en, grant_id, wb_rd_index, wb_data, w, 10 + w, 160 + w);
         end
         $display("test_contention: cycle %0d grant=%0d rd=%0d", k, grant_id, wb_rd_index);
      end
      req_valid = 3'b000;
      tick();
   endtask

   task automatic test_x0();
      logic [N-1:0] exp_ready;
      // pointer is 0 here (round-robin: 6 grants from 0)
      req_valid = 3'b001;
      set_req(0, 5'd0, 64'h55);
      #1;
      checks++;
      if (req_ready !== 3'b001) begin
         errors++; $display("FAIL x0_ready: got %b want 001", req_ready);
      end
      tick();
      req_valid = 3'b000;
      checks++;
      if (wb_en !== 1'b0 || grant_id !== 3'd0) begin
         errors++; $display("FAIL x0_wb_en: got en=%0b id=%0d want 0/0", wb_en, grant_id);
      end
      // pointer advanced to 1: with 0 and 2 requesting, 2 must win
      req_valid = 3'b101;
      set_req(2, 5'd9, 64'h99);
`ifdef WB_ARB_FIXED_PRIO_EN
      exp_ready = 3'b001;
`else
      exp_ready = 3'b100;
`endif
      #1;
      checks++;
      if (req_ready !== exp_ready) begin
         errors++; $display("FAIL x0_ptr_advance: got %b want %b", req_ready, exp_ready);
      end
      $display("test_x0: ready after x0 grant=%b", req_ready);
      tick();
      req_valid = 3'b000;
      tick();
   endtask

   task automatic test_stall();
      logic [2:0] held_id;
      held_id = grant_id;
      stall = 1'b1;
      req_valid = 3'b010;
      set_req(1, 5'd4, 64'h4444);
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (req_ready !== 3'b000) begin
            errors++; $display("FAIL stall_ready[%0d]: got %b want 000", k, req_ready);
         end
         tick();
         checks++;
         if (wb_en !== 1'b0 || grant_id !== held_id) begin
            errors++;
            $display("FAIL stall_wb[%0d]: got en=%0b id=%0d want 0/%0d", k, wb_en, grant_id, held_id);
         end
      end
      stall = 1'b0;
      #1;
      checks++;
      if (req_ready !== 3'b010) begin
         errors++; $display("FAIL stall_release_ready: got %b want 010", req_ready);
      end
      tick();
      req_valid = 3'b000;
      checks++;
      if (wb_en !== 1'b1 || grant_id !== 3'd1 || wb_rd_index !== 5'd4 || wb_data !== 64'h4444) begin
         errors++;
         $display("FAIL stall_release_wb: got en=%0b id=%0d rd=%0d data=%h want 1/1/4/4444",
                  wb_en, grant_id, wb_rd_index, wb_data);
      end
      $display("test_stall: after release en=%0b id=%0d", wb_en, grant_id);
      tick();
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      stall     = 1'b0;
      req_valid = '0;
      req_rd    = '0;
      req_data  = '0;
      tick();
      tick();
      rst = 1'b0;
      test_reset();
      test_single();
      test_contention();
      test_x0();
      test_stall();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
